// File: rtl/lfo_sine_scheduler.sv
// Multi-channel LFO: per-channel rate dividers and 8-bit phase counters sharing one
// sine ROM through a round-robin arbiter. Define LFO_PHASE_OFFSET_EN to add per-channel phase_ofs.
module lfo_sine_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 24,
    parameter int RESET_VAL = 306
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic [NUM_CH-1:0]       phase_rst,
`ifdef LFO_PHASE_OFFSET_EN
    input  logic [NUM_CH*8-1:0]     phase_ofs,
`endif
    output logic                    rom_en,
    output logic [7:0]              rom_addr,
    input  logic [9:0]              rom_data,
    output logic [NUM_CH*10-1:0]    sin_out,
    output logic [NUM_CH-1:0]       sin_valid,
    output logic [NUM_CH-1:0]       overrun
);
    localparam int PTR_W = $clog2(NUM_CH);

    logic [DIV_W-1:0]  cnt   [NUM_CH];
    logic [7:0]        phase [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] tick_raw;
    logic [NUM_CH-1:0] tick;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  winner;
    logic              grant;
    logic [7:0]        addr_next;
    int unsigned       cand;

    logic              s1_valid;
    logic [PTR_W-1:0]  s1_id;
    logic              s2_valid;
    logic [PTR_W-1:0]  s2_id;

    always_comb begin
        tick_raw = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            tick_raw[c] = enable[c] && (cnt[c] == div[c*DIV_W +: DIV_W]);
        end
        // phase_rst suppresses the tick entirely, so it never raises a request
        tick = tick_raw & ~phase_rst;
    end

    // Scanning from the far end downwards leaves the nearest pending channel at or after rr_ptr
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            cand = (32'(rr_ptr) + k - 1) % NUM_CH;
            if (pending[PTR_W'(cand)]) begin
                grant  = 1'b1;
                winner = PTR_W'(cand);
            end
        end
    end

    always_comb begin
`ifdef LFO_PHASE_OFFSET_EN
        addr_next = phase[winner] + phase_ofs[32'(winner)*8 +: 8];
`else
        addr_next = phase[winner];
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt[c]   <= '0;
                phase[c] <= '0;
            end
            pending   <= '0;
            overrun   <= '0;
            rr_ptr    <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_id     <= '0;
            sin_valid <= '0;
            sin_out   <= {NUM_CH{10'(RESET_VAL)}};
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (phase_rst[c]) begin
                    cnt[c]   <= '0;
                    phase[c] <= '0;
                end else if (!enable[c]) begin
                    cnt[c] <= '0;
                end else if (tick_raw[c]) begin
                    cnt[c]   <= '0;
                    phase[c] <= phase[c] + 8'd1;
                end else begin
                    cnt[c] <= cnt[c] + DIV_W'(1);
                end

                // A tick landing on the grant cycle re-arms the request instead of losing it
                if (tick[c]) begin
                    pending[c] <= 1'b1;
                    if (pending[c]) begin
                        overrun[c] <= 1'b1;
                    end
                end else if (grant && (32'(winner) == c)) begin
                    pending[c] <= 1'b0;
                end
            end

            rom_en <= grant;
            if (grant) begin
                rom_addr <= addr_next;
                rr_ptr   <= (32'(winner) == NUM_CH - 1) ? '0 : winner + PTR_W'(1);
            end

            s1_valid <= grant;
            s1_id    <= winner;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;

            sin_valid <= '0;
            if (s2_valid) begin
                sin_out[32'(s2_id)*10 +: 10] <= rom_data;
                sin_valid[s2_id]             <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfo_sine_scheduler.sv
// Directed self-checking bench for lfo_sine_scheduler with a behavioural registered sine ROM.
// Build with LFO_PHASE_OFFSET_EN defined to also exercise the phase offset path.
module tb_lfo_sine_scheduler;
    logic        CLK;
    logic        RST;
    logic [3:0]  enable;
    logic [95:0] div;
    logic [3:0]  phase_rst;
`ifdef LFO_PHASE_OFFSET_EN
    logic [31:0] phase_ofs;
`endif
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [39:0] sin_out;
    logic [3:0]  sin_valid;
    logic [3:0]  overrun;

    logic [9:0]  rom [256];
    int          total;
    int          bad;

    lfo_sine_scheduler #(
        .NUM_CH    (4),
        .DIV_W     (24),
        .RESET_VAL (306)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .div       (div),
        .phase_rst (phase_rst),
`ifdef LFO_PHASE_OFFSET_EN
        .phase_ofs (phase_ofs),
`endif
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sin_out   (sin_out),
        .sin_valid (sin_valid),
        .overrun   (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic apply_reset();
        @(negedge CLK);
        RST       = 1'b1;
        enable    = '0;
        div       = '0;
        phase_rst = '0;
`ifdef LFO_PHASE_OFFSET_EN
        phase_ofs = '0;
`endif
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        enable = 4'b1111;
        repeat (20) @(negedge CLK);
        total++;
        if (overrun !== 4'b1111) begin
            bad++;
            $display("FAIL pre_reset_overrun: got %b expected 1111", overrun);
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        total++;
        if (sin_out !== {4{10'd306}}) begin
            bad++;
            $display("FAIL reset_sin_out: got %h expected %h", sin_out, {4{10'd306}});
        end
        total++;
        if (sin_valid !== 4'b0000 || rom_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: got sin_valid=%b rom_en=%b expected 0000/0", sin_valid, rom_en);
        end
        total++;
        if (overrun !== 4'b0000 || rom_addr !== 8'd0) begin
            bad++;
            $display("FAIL reset_overrun_addr: got overrun=%b rom_addr=%0d expected 0000/0", overrun, rom_addr);
        end
        @(negedge CLK);
        enable = '0;
        RST    = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge CLK);
            total++;
            if (rom_en !== 1'b0 || sin_valid !== 4'b0000) begin
                bad++;
                $display("FAIL idle_quiet: cycle %0d got rom_en=%b sin_valid=%b expected 0/0000", n, rom_en, sin_valid);
            end
        end
        total++;
        if (sin_out !== {4{10'd306}}) begin
            bad++;
            $display("FAIL idle_sin_out: got %h expected %h", sin_out, {4{10'd306}});
        end
    endtask

    task automatic test_single_channel();
        int upd = 0;
        logic [9:0] exp_val;
        apply_reset();
        div[0 +: 24] = 24'd3;
        enable = 4'b0001;
        for (int n = 1; n <= 1027; n++) begin
            @(negedge CLK);
            if (n == 4) begin
                total++;
                if (rom_en !== 1'b0) begin
                    bad++;
                    $display("FAIL ch0_rom_en_early: got %b expected 0", rom_en);
                end
            end
            if (n == 5) begin
                total++;
                if (rom_en !== 1'b1 || rom_addr !== 8'd1) begin
                    bad++;
                    $display("FAIL ch0_first_grant: got rom_en=%b addr=%0d expected 1/1", rom_en, rom_addr);
                end
            end
            if (sin_valid !== 4'b0000) begin
                upd++;
                total++;
                if (sin_valid !== 4'b0001 || n != 4 * upd + 3) begin
                    bad++;
                    $display("FAIL ch0_pulse_timing: update %0d got cycle=%0d sin_valid=%b expected cycle=%0d 0001", upd, n, sin_valid, 4 * upd + 3);
                end
                if (upd == 1 || upd == 64 || upd == 192 || upd == 256) begin
                    exp_val = (upd == 1) ? 10'd312 : (upd == 64) ? 10'd562 : (upd == 192) ? 10'd50 : 10'd306;
                    total++;
                    if (sin_out[9:0] !== exp_val) begin
                        bad++;
                        $display("FAIL ch0_value: update %0d got %0d expected %0d", upd, sin_out[9:0], exp_val);
                    end
                end
            end
        end
        total++;
        if (upd != 256) begin
            bad++;
            $display("FAIL ch0_update_count: got %0d expected 256", upd);
        end
    endtask

    task automatic test_all_channels();
        logic [3:0] exp_v;
        apply_reset();
        enable = 4'b1111;
        for (int n = 1; n <= 41; n++) begin
            @(negedge CLK);
            if (n >= 2) begin
                total++;
                if (rom_en !== 1'b1) begin
                    bad++;
                    $display("FAIL all_rom_en: cycle %0d got %b expected 1", n, rom_en);
                end
            end
            exp_v = (n >= 4) ? 4'(1 << ((n - 4) % 4)) : 4'b0000;
            total++;
            if (sin_valid !== exp_v) begin
                bad++;
                $display("FAIL all_grant_order: cycle %0d got %b expected %b", n, sin_valid, exp_v);
            end
            if (n == 4) begin
                total++;
                if (sin_out[9:0] !== 10'd312) begin
                    bad++;
                    $display("FAIL all_ch0_first: got %0d expected 312", sin_out[9:0]);
                end
            end
            if (n == 5) begin
                total++;
                if (sin_out[19:10] !== 10'd319) begin
                    bad++;
                    $display("FAIL all_ch1_first: got %0d expected 319", sin_out[19:10]);
                end
            end
        end
        total++;
        if (overrun !== 4'b1111) begin
            bad++;
            $display("FAIL all_overrun: got %b expected 1111", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        apply_reset();
        div[0 +: 24]  = 24'd9;
        div[24 +: 24] = 24'd9;
        enable = 4'b0011;
        for (int n = 1; n <= 45; n++) begin
            @(negedge CLK);
            if (n == 11 || n == 12) begin
                total++;
                if (rom_en !== 1'b1 || rom_addr !== 8'd1) begin
                    bad++;
                    $display("FAIL b2b_grant: cycle %0d got rom_en=%b addr=%0d expected 1/1", n, rom_en, rom_addr);
                end
            end
            exp_v = 4'b0000;
            if (n >= 13 && (n - 13) % 10 == 0) exp_v = 4'b0001;
            if (n >= 14 && (n - 14) % 10 == 0) exp_v = 4'b0010;
            total++;
            if (sin_valid !== exp_v) begin
                bad++;
                $display("FAIL b2b_pulses: cycle %0d got %b expected %b", n, sin_valid, exp_v);
            end
            if (n == 13 || n == 14) begin
                total++;
                if (sin_out[(n - 13) * 10 +: 10] !== 10'd312) begin
                    bad++;
                    $display("FAIL b2b_value: cycle %0d got %0d expected 312", n, sin_out[(n - 13) * 10 +: 10]);
                end
            end
        end
        total++;
        if (overrun !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_overrun: got %b expected 0000", overrun);
        end
    endtask

    task automatic test_phase_rst();
        int pulses = 0;
        int hit = 0;
        int found = 0;
        apply_reset();
        div[48 +: 24] = 24'd3;
        enable = 4'b0100;
        for (int n = 1; n <= 500 && hit == 0; n++) begin
            @(negedge CLK);
            if (sin_valid[2]) begin
                pulses++;
                if (pulses == 100) hit = n;
            end
        end
        total++;
        if (hit != 403) begin
            bad++;
            $display("FAIL ch2_phase100_time: got cycle %0d expected 403", hit);
        end
        total++;
        if (sin_out[29:20] !== 10'd468) begin
            bad++;
            $display("FAIL ch2_phase100_value: got %0d expected 468", sin_out[29:20]);
        end
        // Next edge is a tick edge for ch2; phase_rst must override it
        phase_rst = 4'b0100;
        for (int w = 1; w <= 20 && found == 0; w++) begin
            @(negedge CLK);
            if (w == 1) phase_rst = 4'b0000;
            if (sin_valid[2]) found = w;
        end
        total++;
        if (found != 8) begin
            bad++;
            $display("FAIL ch2_after_rst_time: got %0d cycles expected 8", found);
        end
        total++;
        if (sin_out[29:20] !== 10'd312) begin
            bad++;
            $display("FAIL ch2_after_rst_value: got %0d expected 312", sin_out[29:20]);
        end
    endtask

`ifdef LFO_PHASE_OFFSET_EN
    task automatic test_phase_offset();
        apply_reset();
        div[0 +: 24]   = 24'd3;
        div[24 +: 24]  = 24'd3;
        phase_ofs[8 +: 8] = 8'd64;
        enable = 4'b0011;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (n >= 5 && (n - 5) % 4 == 0) begin
                total++;
                if (rom_en !== 1'b1 || rom_addr !== 8'((n - 1) / 4)) begin
                    bad++;
                    $display("FAIL ofs_ch0_addr: cycle %0d got en=%b addr=%0d expected 1/%0d", n, rom_en, rom_addr, (n - 1) / 4);
                end
            end
            if (n >= 6 && (n - 6) % 4 == 0) begin
                total++;
                if (rom_en !== 1'b1 || rom_addr !== 8'((n - 2) / 4 + 64)) begin
                    bad++;
                    $display("FAIL ofs_ch1_addr: cycle %0d got en=%b addr=%0d expected 1/%0d", n, rom_en, rom_addr, (n - 2) / 4 + 64);
                end
            end
            if (n == 7) begin
                total++;
                if (sin_valid !== 4'b0001 || sin_out[9:0] !== 10'd312) begin
                    bad++;
                    $display("FAIL ofs_pair_ch0: got valid=%b val=%0d expected 0001/312", sin_valid, sin_out[9:0]);
                end
            end
            if (n == 8) begin
                total++;
                if (sin_valid !== 4'b0010 || sin_out[19:10] !== 10'd562) begin
                    bad++;
                    $display("FAIL ofs_pair_ch1: got valid=%b val=%0d expected 0010/562", sin_valid, sin_out[19:10]);
                end
            end
        end
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        RST       = 1'b1;
        enable    = '0;
        div       = '0;
        phase_rst = '0;
`ifdef LFO_PHASE_OFFSET_EN
        phase_ofs = '0;
`endif
        for (int i = 0; i < 256; i++) begin
            rom[i] = 10'($rtoi(306.0 + 256.0 * $sin(2.0 * 3.141592653589793 * i / 256.0) + 0.5));
        end
        test_reset();
        test_single_channel();
        test_all_channels();
        test_back_to_back();
        test_phase_rst();
`ifdef LFO_PHASE_OFFSET_EN
        test_phase_offset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
